fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single write port of the `dual_port_ram` frame buffer (13-bit address, 12-bit colour) between two pixel writers and a built-in clear engine. The read port stays with display scan-out and is not touched by this block. The block sits between the renderers and the RAM. It drives `write_addr`/`din` directly, plus a write strobe. Idle cycles are parked on a scratch word, so the block works with a RAM that writes every cycle.

## Interface
- `ADDR_W`, 13, frame-buffer address width
- `DATA_W`, 12, pixel/colour width
- `CLEAR_LAST`, 8190, last address written by a clear sweep (sweep covers 0..CLEAR_LAST)
- `PARK_ADDR`, 8191, scratch address driven when no write is active
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `clear_req`  in  1  one-cycle pulse: start a full-buffer clear
- `clear_color`  in  DATA_W  fill value, sampled with `clear_req`
- `clear_busy`  out  1  clear sweep in progress
- `req0_valid`, `req1_valid`  in  1  requester has a pixel write
- `req0_addr`, `req1_addr`  in  ADDR_W  target address
- `req0_data`, `req1_data`  in  DATA_W  pixel value
- `req0_ready`, `req1_ready`  out  1  write accepted this cycle
- `ram_we`  out  1  write strobe to RAM
- `ram_waddr`  out  ADDR_W  to RAM `write_addr`
- `ram_wdata`  out  DATA_W  to RAM `din`

## Operation
- States: IDLE (requester service) and CLEAR (sweep).
- IDLE, clear_req=0:
  - One valid requester: it gets ready=1.
  - Both valid: round-robin. The requester not granted most recently wins.
  - The round-robin pointer updates only on a grant.
- Handshake: a write transfers when `reqN_valid && reqN_ready`.
  - Ready is combinational from the valids, the state and the pointer.
  - A requester must hold addr/data stable until its transfer.
- IDLE with clear_req=1:
  - Enter CLEAR and latch clear_color.
  - Both readies are 0 that cycle. Clear wins over any same-cycle request.
- CLEAR:
  - An ADDR_W counter runs 0..CLEAR_LAST, issuing one write per cycle with the latched colour.
  - Both readies are held 0 throughout.
  - clear_req is ignored. There is no queuing and no restart.
  - After the write of CLEAR_LAST is issued, return to IDLE. The counter does not wrap.
- No write issued: drive ram_we=0, ram_waddr=PARK_ADDR, ram_wdata=0.
- Writes addressed to PARK_ADDR are legal and are passed through. Renderers must not store live pixels there.

## Timing
- All ram_* outputs and clear_busy are registered.
- Reset values:
  - ram_we=0, ram_waddr=PARK_ADDR, ram_wdata=0.
  - clear_busy=0, state IDLE, pointer favours req0.
  - Both readies 0 during the reset cycle.
- Requester write latency: accepted in cycle N, presented on ram_* in cycle N+1.
- Throughput: one write per cycle, with back-to-back grants.
- Clear sequence:
  - clear_req in cycle N → clear_busy=1 from N+1.
  - Address 0 appears on ram_* in N+2.
  - Address CLEAR_LAST appears in N+2+CLEAR_LAST.
  - clear_busy falls in that same cycle.
  - The first requester can be accepted in N+2+CLEAR_LAST and be written the next cycle.
- Reset mid-clear aborts the sweep immediately. Partially cleared contents are left as is.

## Structure
- Shared package `fb_pkg`: ADDR_W/DATA_W defaults, the PARK_ADDR/CLEAR_LAST constants, and the state enum {IDLE, CLEAR}.
- One sub-module: `rr_arbiter2`.
  - Inputs: two requests and an enable.
  - Outputs: one-hot grant.
  - Holds the last-grant pointer, updated on grant.
- The top holds the FSM, the clear counter and the output registers.

## Test plan
- Reset: hold rst=1 for 3 cycles → ram_we=0, ram_waddr=8191, clear_busy=0, readies 0.
- Single requester: req0 writes (addr 100, data 0x00A) in cycle N → ram_we=1, ram_waddr=100, ram_wdata=0x00A in N+1; req1_ready stays 0.
- Contention: both valid continuously, with req0 at (5, 0x111) and req1 at (6, 0x222) → ram_* alternates 5, 6, 5, 6 starting with req0 after reset; no cycle has ram_we=0.
- Clear: clear_req with colour 0xF00 → addresses 0..8190 each written once with 0xF00, in order; clear_busy high for exactly 8191 cycles; req1 held valid during the sweep is accepted only after clear_busy falls.
- Collision and abort:
  - clear_req and req0_valid in the same cycle → req0 not accepted; the sweep starts.
  - rst asserted at sweep address 2000 → next cycle shows reset values, with IDLE and no further clear writes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer write-path constants and types.
package fb_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 12;

  // Clear sweeps 0..CLEAR_LAST; the word above it is the idle parking slot.
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(8190);
  localparam logic [ADDR_W-1:0] PARK_ADDR  = ADDR_W'(8191);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Renderer/clear request side and RAM write side of the frame-buffer write port.
interface fb_write_arbiter_if;
  import fb_pkg::*;

  logic              clear_req;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Arbiter side.
  modport slave (
    input  clear_req, clear_color,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output clear_busy, req0_ready, req1_ready,
    output ram_we, ram_waddr, ram_wdata
  );

  // Requester / RAM-observer side.
  modport master (
    output clear_req, clear_color,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  clear_busy, req0_ready, req1_ready,
    input  ram_we, ram_waddr, ram_wdata
  );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not granted most recently wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  // prio1_q=1 means req1 wins the next tie; reset favours req0.
  logic prio1_q, prio1_d;

  // Grant selection and pointer update on grant only.
  always_comb begin
    gnt_c   = 2'b00;
    prio1_d = prio1_q;
    if (en) begin
      if (req[0] && (!req[1] || !prio1_q)) begin
        gnt_c = 2'b01;
      end else if (req[1]) begin
        gnt_c = 2'b10;
      end
    end
    if (gnt_c[0]) begin
      prio1_d = 1'b1;
    end else if (gnt_c[1]) begin
      prio1_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: two pixel writers plus a full-buffer clear engine.
module fb_write_arbiter
  import fb_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fb_write_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              clear_busy_q, clear_busy_d;

  logic              arb_en_c;
  logic [1:0]        gnt_c;

  // Requesters are only served in IDLE, and a same-cycle clear takes precedence.
  assign arb_en_c = (state_q == IDLE) && !bus.clear_req && !rst;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en_c),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .gnt_c (gnt_c)
  );

  assign bus.req0_ready = gnt_c[0];
  assign bus.req1_ready = gnt_c[1];
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_waddr  = ram_waddr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.clear_busy = clear_busy_q;

  // Next state, sweep counter and the write to present next cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = PARK_ADDR;
    ram_wdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = bus.clear_color;
        end else if (gnt_c[0]) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = bus.req0_addr;
          ram_wdata_d = bus.req0_data;
        end else if (gnt_c[1]) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = bus.req1_addr;
          ram_wdata_d = bus.req1_data;
        end
      end
      CLEAR: begin
        ram_we_d    = 1'b1;
        ram_waddr_d = cnt_q;
        ram_wdata_d = color_q;
        if (cnt_q == CLEAR_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    clear_busy_d = (state_d == CLEAR);
  end

  // State and output registers; reset also aborts a sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      color_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= PARK_ADDR;
      ram_wdata_q  <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      color_q      <= color_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      clear_busy_q <= clear_busy_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a write scoreboard.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_write_arbiter_if bus ();

  fb_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM-side monitor: every write must match the scoreboard head; idle cycles must be parked.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ram_we === 1'b1) begin
        chk("sb_nonempty", 16'(sb.size() > 0), 16'd1);
        if (sb.size() > 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("ram_waddr", 16'(bus.ram_waddr), 16'(e.a));
          chk("ram_wdata", 16'(bus.ram_wdata), 16'(e.d));
        end
      end else begin
        chk("idle_we", 16'(bus.ram_we), 16'd0);
        chk("park_addr", 16'(bus.ram_waddr), 16'(PARK_ADDR));
        chk("park_data", 16'(bus.ram_wdata), 16'd0);
      end
    end
  end

  // One cycle: check readies/busy/we mid-cycle, log expected transfers, advance.
  task automatic step(input logic r0, input logic r1, input logic busy, input int we);
    @(negedge clk);
    chk("req0_ready", 16'(bus.req0_ready), 16'(r0));
    chk("req1_ready", 16'(bus.req1_ready), 16'(r1));
    chk("clear_busy", 16'(bus.clear_busy), 16'(busy));
    if (we >= 0) chk("ram_we", 16'(bus.ram_we), 16'(we));
    if (r0) sb.push_back('{a: bus.req0_addr, d: bus.req0_data});
    if (r1) sb.push_back('{a: bus.req1_addr, d: bus.req1_data});
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input int a, input int d);
    bus.req0_valid = v;
    bus.req0_addr  = ADDR_W'(a);
    bus.req0_data  = DATA_W'(d);
  endtask

  task automatic set1(input logic v, input int a, input int d);
    bus.req1_valid = v;
    bus.req1_addr  = ADDR_W'(a);
    bus.req1_data  = DATA_W'(d);
  endtask

  initial begin
    bus.clear_req   = 1'b0;
    bus.clear_color = '0;
    set0(1'b1, 100, 'h00A);
    set1(1'b0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held for three cycles with a requester waiting.
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // Contention: strict alternation starting with req0, no idle write slots.
    set0(1'b1, 5, 'h111);
    set1(1'b1, 6, 'h222);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1);

    // Single requesters.
    set1(1'b0, 0, 0);
    set0(1'b1, 100, 'h00A);
    step(1'b1, 1'b0, 1'b0, 1);
    set0(1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    set1(1'b1, 300, 'h3C3);
    step(1'b0, 1'b1, 1'b0, 0);
    set1(1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);

    // Clear colliding with req0; req1 waits out the whole sweep.
    bus.clear_req   = 1'b1;
    bus.clear_color = DATA_W'('hF00);
    set0(1'b1, 7, 'h777);
    step(1'b0, 1'b0, 1'b0, 0);
    bus.clear_req   = 1'b0;
    bus.clear_color = '0;
    set0(1'b0, 0, 0);
    set1(1'b1, 9, 'h999);
    for (int i = 0; i <= int'(CLEAR_LAST); i++) sb.push_back('{a: ADDR_W'(i), d: DATA_W'('hF00)});
    step(1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= int'(CLEAR_LAST); i++) step(1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 1);
    set1(1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);

    // Leave the pointer favouring req1 so the post-reset tie shows it was reset.
    set0(1'b1, 20, 'h202);
    step(1'b1, 1'b0, 1'b0, 0);
    set0(1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);

    // Sweep aborted by reset while address 2000 is on the RAM port.
    bus.clear_req   = 1'b1;
    bus.clear_color = DATA_W'('h0AB);
    step(1'b0, 1'b0, 1'b0, 0);
    bus.clear_req = 1'b0;
    for (int i = 0; i <= 2000; i++) sb.push_back('{a: ADDR_W'(i), d: DATA_W'('h0AB)});
    step(1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= 2000; i++) step(1'b0, 1'b0, 1'b1, 1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1);
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);

    // Pointer back to favouring req0 after reset.
    set0(1'b1, 11, 'h0B1);
    set1(1'b1, 12, 'h0C2);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1);
    set0(1'b0, 0, 0);
    set1(1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
